// File: rtl/rv32i_mc_core.sv
// Multicycle RV32I core with request/ready instruction and data ports.
// Optional TRAP_ON_ILLEGAL_EN: unknown opcodes and misaligned targets halt with trap.
//   state  | meaning
//   FETCH  | imem_req held until imem_ready, instruction captured into ir
//   DECODE | register operands and immediate latched
//   EXEC   | ALU / link / upper-immediate result and next pc latched
//   MEM    | dmem_req held until dmem_ready, load data captured
//   WB     | rd written, pc updated, retire pulse
//   HALT   | stopped after EBREAK or trap, left only by reset
module rv32i_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [2:0]  dmem_funct3,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        retire,
   output logic        halted,
   output logic        trap
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t      state;
   logic [31:0] pc, ir, rs1_v, rs2_v, imm, alu_r, npc;
   logic [31:0] rf [0:31];
`ifdef TRAP_ON_ILLEGAL_EN
   logic        trap_r;
`endif

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1_a, rs2_a;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_imm, is_reg;
   logic        is_ebreak, writes_rd, br_taken, redirect;
   logic [31:0] imm_dec, op_b, alu_out, exec_res, tgt, pc_plus4, pc_imm, npc_calc;
   logic [4:0]  shamt;

   assign opcode    = ir[6:0];
   assign f3        = ir[14:12];
   assign rd        = ir[11:7];
   assign rs1_a     = ir[19:15];
   assign rs2_a     = ir[24:20];
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_imm    = (opcode == OP_IMM);
   assign is_reg    = (opcode == OP_REG);
   assign is_ebreak = (ir == 32'h0010_0073);
   assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_load | is_imm | is_reg;

   always_comb begin
      case (opcode)
         OP_STORE:        imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH:       imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'b0};
         OP_JAL:          imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:         imm_dec = {{20{ir[31]}}, ir[31:20]};
      endcase
   end

   // loads, stores and anything that is not OP/OP-IMM use the adder for rs1+imm
   assign op_b  = is_reg ? rs2_v : imm;
   assign shamt = op_b[4:0];
   always_comb begin
      alu_out = rs1_v + op_b;
      if (is_reg || is_imm) begin
         case (f3)
            3'b000:  alu_out = (is_reg && ir[30]) ? rs1_v - op_b : rs1_v + op_b;
            3'b001:  alu_out = rs1_v << shamt;
            3'b010:  alu_out = {31'b0, $signed(rs1_v) < $signed(op_b)};
            3'b011:  alu_out = {31'b0, rs1_v < op_b};
            3'b100:  alu_out = rs1_v ^ op_b;
            3'b101:  alu_out = ir[30] ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'b110:  alu_out = rs1_v | op_b;
            default: alu_out = rs1_v & op_b;
         endcase
      end
   end

   always_comb begin
      case (f3)
         3'b000:  br_taken = (rs1_v == rs2_v);
         3'b001:  br_taken = (rs1_v != rs2_v);
         3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
         3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110:  br_taken = (rs1_v < rs2_v);
         3'b111:  br_taken = (rs1_v >= rs2_v);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc + 32'd4;
   assign pc_imm   = pc + imm;
   assign tgt      = is_jalr ? ((rs1_v + imm) & 32'hFFFF_FFFE) : pc_imm;
   assign redirect = is_jal | is_jalr | (is_branch & br_taken);
`ifdef TRAP_ON_ILLEGAL_EN
   logic known, fault;
   assign known = writes_rd | is_branch | is_store | (opcode == 7'b0001111) | (opcode == 7'b1110011);
   assign fault = !known || (redirect && tgt[1:0] != 2'b00);
   assign npc_calc = redirect ? tgt : pc_plus4;
`else
   assign npc_calc = redirect ? (tgt & 32'hFFFF_FFFC) : pc_plus4;
`endif

   always_comb begin
      if (is_lui)                exec_res = imm;
      else if (is_auipc)         exec_res = pc_imm;
      else if (is_jal || is_jalr) exec_res = pc_plus4;
      else                       exec_res = alu_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
      end else begin
         case (state)
            FETCH: if (imem_ready) begin
               ir    <= imem_rdata;
               state <= DECODE;
            end
            DECODE: begin
               rs1_v <= (rs1_a == 5'd0) ? 32'd0 : rf[rs1_a];
               rs2_v <= (rs2_a == 5'd0) ? 32'd0 : rf[rs2_a];
               imm   <= imm_dec;
               state <= EXEC;
            end
            EXEC: begin
               alu_r <= exec_res;
               npc   <= npc_calc;
`ifdef TRAP_ON_ILLEGAL_EN
               if (fault) begin
                  state  <= HALT;
                  trap_r <= 1'b1;
               end else
`endif
               if (is_load || is_store) state <= MEM;
               else                     state <= WB;
            end
            MEM: if (dmem_ready) begin
               if (!is_store) alu_r <= dmem_rdata;
               state <= WB;
            end
            WB: begin
               if (writes_rd && rd != 5'd0) rf[rd] <= alu_r;
               pc    <= npc;
               state <= is_ebreak ? HALT : FETCH;
`ifdef TRAP_ON_ILLEGAL_EN
               trap_r <= 1'b0;
`endif
            end
            default: state <= HALT;
         endcase
      end
   end

   // request strobes drop combinationally so a reset abandons an in-flight access
   assign imem_req    = (state == FETCH) && !reset;
   assign imem_addr   = pc;
   assign dmem_req    = (state == MEM) && !reset;
   assign dmem_we     = is_store;
   assign dmem_addr   = alu_r;
   assign dmem_wdata  = rs2_v;
   assign dmem_funct3 = f3;
   assign retire      = (state == WB) && !reset;
   assign halted      = (state == HALT) && !reset;
`ifdef TRAP_ON_ILLEGAL_EN
   assign trap        = (state == HALT) && trap_r && !reset;
`else
   assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core with behavioural instruction/data memories.
// Data memory latency is programmable; results are observed through stores.
module tb_rv32i_mc_core;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, trap;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [2:0]  dmem_funct3;

   int assertions = 0;
   int failures   = 0;

   logic [31:0] imem [0:63];
   logic [31:0] dmem [0:15];
   int          dmem_delay = 0;
   logic        dmem_clear = 1'b0;
   int          dcnt = 0;

   int          ret_cyc[$];
   logic [31:0] fetch_addr[$];
   int          dreq_cycles, unstable;
   logic        first_seen;
   logic [31:0] first_daddr, first_dwdata;
   logic [2:0]  first_df3;

   always #5 clk = ~clk;

   rv32i_mc_core #(.RESET_PC(32'h0000_1000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_funct3(dmem_funct3), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .retire(retire), .halted(halted), .trap(trap)
   );

   assign imem_ready = 1'b1;
   assign imem_rdata = imem[imem_addr[7:2]];
   assign dmem_ready = dmem_req && (dcnt == dmem_delay);
   assign dmem_rdata = dmem[dmem_addr[5:2]];

   always @(posedge clk) begin
      if (dmem_clear) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 32'hA5A5_A5A5;
      end else if (!reset && dmem_req && dmem_ready && dmem_we) begin
         dmem[dmem_addr[5:2]] <= dmem_wdata;
      end
      if (reset || !dmem_req || dmem_ready) dcnt <= 0;
      else dcnt <= dcnt + 1;
   end

   task automatic start_reset();
      @(negedge clk);
      reset = 1'b1;
      dmem_clear = 1'b1;
      for (int i = 0; i < 64; i++) imem[i] = EBREAK;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      reset = 1'b0;
      dmem_clear = 1'b0;
   endtask

   // steps from a negedge until halted or the cycle budget runs out, logging activity
   task automatic run(input int max_cyc);
      logic pend;
      logic [31:0] pa, pw;
      logic pwe;
      ret_cyc.delete();
      fetch_addr.delete();
      dreq_cycles = 0; unstable = 0; first_seen = 1'b0; pend = 1'b0;
      pa = '0; pw = '0; pwe = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         #1;
         if (retire) ret_cyc.push_back(i);
         if (imem_req && imem_ready) fetch_addr.push_back(imem_addr);
         if (dmem_req) begin
            dreq_cycles++;
            if (!first_seen) begin
               first_seen = 1'b1; first_daddr = dmem_addr; first_dwdata = dmem_wdata; first_df3 = dmem_funct3;
            end
            if (pend && (dmem_addr !== pa || dmem_wdata !== pw || dmem_we !== pwe)) unstable++;
            pend = !dmem_ready; pa = dmem_addr; pw = dmem_wdata; pwe = dmem_we;
         end else begin
            pend = 1'b0;
         end
         if (halted) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      start_reset();
      #1;
      assertions++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req: got %b expected 0", imem_req); end
      assertions++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_dmem_req: got %b expected 0", dmem_req); end
      assertions++; if ({retire, halted, trap} !== 3'b000) begin failures++; $display("FAIL rst_status: got %b expected 000", {retire, halted, trap}); end
      imem[0] = 32'h0050_0093;   // addi x1,x0,5
      imem[1] = 32'hFF90_8113;   // addi x2,x1,-7
      imem[2] = 32'h0020_2423;   // sw x2,8(x0)
      @(negedge clk);
      release_reset();
      #1;
      assertions++; if (imem_addr !== 32'h1000 || imem_req !== 1'b1) begin failures++; $display("FAIL first_fetch: got %h/%b expected 00001000/1", imem_addr, imem_req); end
      run(100);
      assertions++; if (ret_cyc.size() != 4) begin failures++; $display("FAIL retire_count: got %0d expected 4", ret_cyc.size()); end
      assertions++; if (ret_cyc[0] != 3) begin failures++; $display("FAIL first_retire: got %0d expected 3", ret_cyc[0]); end
      assertions++; if (ret_cyc[1] - ret_cyc[0] != 4) begin failures++; $display("FAIL alu_latency: got %0d expected 4", ret_cyc[1] - ret_cyc[0]); end
      assertions++; if (ret_cyc[2] - ret_cyc[1] != 5) begin failures++; $display("FAIL store_latency: got %0d expected 5", ret_cyc[2] - ret_cyc[1]); end
      assertions++; if (dmem[2] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL x2_value: got %h expected fffffffe", dmem[2]); end
      assertions++; if (halted !== 1'b1 || trap !== 1'b0) begin failures++; $display("FAIL ebreak_halt: got %b/%b expected 1/0", halted, trap); end
      repeat (5) @(negedge clk);
      #1;
      assertions++; if (halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_sticky: got %b/%b expected 1/0", halted, imem_req); end
   endtask

   task automatic test_alu();
      start_reset();
      imem[0]  = 32'hFFD0_0093;  // addi x1,x0,-3
      imem[1]  = 32'h0050_0113;  // addi x2,x0,5
      imem[2]  = 32'h0020_81B3;  // add x3,x1,x2
      imem[3]  = 32'h4020_8233;  // sub x4,x1,x2
      imem[4]  = 32'h0011_33B3;  // sltu x7,x2,x1
      imem[5]  = 32'h4010_D413;  // srai x8,x1,1
      imem[6]  = 32'h1234_54B7;  // lui x9,0x12345
      imem[7]  = 32'h0030_2023;  // sw x3,0(x0)
      imem[8]  = 32'h0040_2223;  // sw x4,4(x0)
      imem[9]  = 32'h0070_2423;  // sw x7,8(x0)
      imem[10] = 32'h0080_2623;  // sw x8,12(x0)
      imem[11] = 32'h0090_2823;  // sw x9,16(x0)
      @(negedge clk);
      release_reset();
      run(200);
      assertions++; if (dmem[0] !== 32'h0000_0002) begin failures++; $display("FAIL add: got %h expected 00000002", dmem[0]); end
      assertions++; if (dmem[1] !== 32'hFFFF_FFF8) begin failures++; $display("FAIL sub: got %h expected fffffff8", dmem[1]); end
      assertions++; if (dmem[2] !== 32'h0000_0001) begin failures++; $display("FAIL sltu: got %h expected 00000001", dmem[2]); end
      assertions++; if (dmem[3] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL srai: got %h expected fffffffe", dmem[3]); end
      assertions++; if (dmem[4] !== 32'h1234_5000) begin failures++; $display("FAIL lui: got %h expected 12345000", dmem[4]); end
      assertions++; if (halted !== 1'b1) begin failures++; $display("FAIL alu_halt: got %b expected 1", halted); end
   endtask

   task automatic test_mem_wait();
      start_reset();
      dmem_delay = 3;
      imem[0] = 32'h0050_0093;   // addi x1,x0,5
      imem[1] = 32'hFF90_8113;   // addi x2,x1,-7
      imem[2] = 32'h0020_2423;   // sw x2,8(x0)
      imem[3] = 32'h0080_2183;   // lw x3,8(x0)
      imem[4] = 32'h0030_2623;   // sw x3,12(x0)
      @(negedge clk);
      release_reset();
      run(200);
      assertions++; if (first_daddr !== 32'h8 || first_dwdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wait_req: got %h/%h expected 00000008/fffffffe", first_daddr, first_dwdata); end
      assertions++; if (first_df3 !== 3'b010) begin failures++; $display("FAIL wait_funct3: got %b expected 010", first_df3); end
      assertions++; if (unstable != 0) begin failures++; $display("FAIL req_stable: got %0d changes expected 0", unstable); end
      assertions++; if (dreq_cycles != 12) begin failures++; $display("FAIL dreq_cycles: got %0d expected 12", dreq_cycles); end
      assertions++; if (ret_cyc[2] - ret_cyc[1] != 8) begin failures++; $display("FAIL sw_wait_latency: got %0d expected 8", ret_cyc[2] - ret_cyc[1]); end
      assertions++; if (ret_cyc[3] - ret_cyc[2] != 8) begin failures++; $display("FAIL lw_wait_latency: got %0d expected 8", ret_cyc[3] - ret_cyc[2]); end
      assertions++; if (dmem[3] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL lw_value: got %h expected fffffffe", dmem[3]); end
      dmem_delay = 0;
   endtask

   task automatic test_branch();
      logic [31:0] exp [5];
      start_reset();
      imem[0] = 32'h0100_006F;   // jal x0,16     -> 0x1010
      imem[1] = 32'h0000_0013;
      imem[2] = 32'h00C0_006F;   // jal x0,12     -> 0x1014
      imem[3] = 32'h0000_0013;
      imem[4] = 32'hFE00_0CE3;   // beq x0,x0,-8  -> 0x1008
      imem[5] = 32'hFE00_1CE3;   // bne x0,x0,-8  -> falls through
      exp[0] = 32'h1000; exp[1] = 32'h1010; exp[2] = 32'h1008; exp[3] = 32'h1014; exp[4] = 32'h1018;
      @(negedge clk);
      release_reset();
      run(100);
      assertions++; if (fetch_addr.size() != 5) begin failures++; $display("FAIL br_fetch_count: got %0d expected 5", fetch_addr.size()); end
      for (int k = 0; k < 5; k++) begin
         assertions++; if (fetch_addr[k] !== exp[k]) begin failures++; $display("FAIL br_fetch_%0d: got %h expected %h", k, fetch_addr[k], exp[k]); end
      end
   endtask

   task automatic test_jump();
      logic [31:0] exp [6];
      start_reset();
      imem[0]  = 32'h0200_006F;  // jal x0,32      -> 0x1020
      imem[8]  = 32'h0100_00EF;  // jal x1,16      -> 0x1030
      imem[12] = 32'h0010_82E7;  // jalr x5,x1,1   -> 0x1024
      imem[9]  = 32'h0010_2823;  // sw x1,16(x0)
      imem[10] = 32'h0050_2A23;  // sw x5,20(x0)
      exp[0] = 32'h1000; exp[1] = 32'h1020; exp[2] = 32'h1030; exp[3] = 32'h1024; exp[4] = 32'h1028; exp[5] = 32'h102C;
      @(negedge clk);
      release_reset();
      run(100);
      for (int k = 0; k < 6; k++) begin
         assertions++; if (fetch_addr[k] !== exp[k]) begin failures++; $display("FAIL jmp_fetch_%0d: got %h expected %h", k, fetch_addr[k], exp[k]); end
      end
      assertions++; if (dmem[4] !== 32'h1024) begin failures++; $display("FAIL jal_link: got %h expected 00001024", dmem[4]); end
      assertions++; if (dmem[5] !== 32'h1034) begin failures++; $display("FAIL jalr_link: got %h expected 00001034", dmem[5]); end
   endtask

   task automatic test_reset_mid_store();
      start_reset();
      dmem_delay = 3;
      imem[0] = 32'h0770_0313;   // addi x6,x0,0x77
      imem[1] = 32'h0060_2423;   // sw x6,8(x0)
      @(negedge clk);
      release_reset();
      #1;
      for (int i = 0; i < 20 && !dmem_req; i++) begin
         @(negedge clk);
         #1;
      end
      assertions++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL mid_store_reach: got %b expected 1", dmem_req); end
      reset = 1'b1;
      #1;
      assertions++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL mid_store_drop: got %b%b%b expected 000", dmem_req, imem_req, retire); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      assertions++; if (imem_addr !== 32'h1000 || imem_req !== 1'b1) begin failures++; $display("FAIL mid_store_refetch: got %h/%b expected 00001000/1", imem_addr, imem_req); end
      assertions++; if (dmem[2] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mid_store_mem: got %h expected a5a5a5a5", dmem[2]); end
      run(100);
      assertions++; if (dmem[2] !== 32'h0000_0077 || halted !== 1'b1) begin failures++; $display("FAIL rerun_store: got %h/%b expected 00000077/1", dmem[2], halted); end
      dmem_delay = 0;
   endtask

   task automatic test_illegal();
      start_reset();
      imem[0] = 32'hFFFF_FFFF;
      @(negedge clk);
      release_reset();
      run(100);
      assertions++; if (halted !== 1'b1) begin failures++; $display("FAIL ill_halted: got %b expected 1", halted); end
`ifdef TRAP_ON_ILLEGAL_EN
      assertions++; if (trap !== 1'b1) begin failures++; $display("FAIL ill_trap: got %b expected 1", trap); end
      assertions++; if (ret_cyc.size() != 0) begin failures++; $display("FAIL ill_retire: got %0d expected 0", ret_cyc.size()); end
      assertions++; if (imem_addr !== 32'h1000) begin failures++; $display("FAIL ill_pc: got %h expected 00001000", imem_addr); end
`else
      assertions++; if (trap !== 1'b0) begin failures++; $display("FAIL ill_trap: got %b expected 0", trap); end
      assertions++; if (ret_cyc.size() != 2) begin failures++; $display("FAIL ill_retire: got %0d expected 2", ret_cyc.size()); end
      assertions++; if (fetch_addr[1] !== 32'h1004) begin failures++; $display("FAIL ill_next_pc: got %h expected 00001004", fetch_addr[1]); end
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_jump();
      test_reset_mid_store();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
